if_stage: RTL

Instruction-fetch stage of the five-stage pipeline: it is the consumer end of the execute stage's branch-resolution outputs. It holds the program counter and drives the instruction-memory address. On a taken branch resolved in EXE it redirects fetch and flushes the IF/ID pipeline register. It also honours the hazard unit's freeze and keeps two saturating event counters for debug.

---
 rtl/if_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the five-stage pipeline.
//
// Holds the program counter, drives the instruction-memory address and
// registers the fetched word into the IF/ID pipeline register. A taken
// branch resolved in EXE redirects the PC and inserts a bubble into IF/ID.
// A freeze from the hazard unit holds the PC and IF/ID. Two saturating
// debug counters track taken redirects and honoured freeze cycles.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous active-high reset
//   freeze         hazard stall: hold PC and IF/ID
//   branch_taken   taken branch resolved in EXE this cycle
//   branch_address redirect target (low two bits ignored)
//   instr_addr     instruction-memory read address (= PC register)
//   instr_data     instruction word read combinationally at instr_addr
//   id_instr       IF/ID instruction
//   id_pc          IF/ID PC of id_instr
//   id_valid       IF/ID valid (0 = bubble)
//   flush          squash for the ID/EXE register, equal to branch_taken
//   branch_count   saturating count of taken redirects
//   stall_count    saturating count of honoured freeze cycles

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] stall_count
);

  logic [31:0] pc;

  // Word alignment: the two low target bits are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^branch_address[1:0];

  assign instr_addr = pc;
  assign flush      = branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      id_instr     <= NOP_INSTR;
      id_pc        <= 32'h0;
      id_valid     <= 1'b0;
      branch_count <= 16'h0;
      stall_count  <= 16'h0;
    end else if (branch_taken) begin
      // Branch beats freeze: the EXE instruction is older than the stalled one.
      pc       <= {branch_address[31:2], 2'b00};
      id_instr <= NOP_INSTR;
      id_pc    <= 32'h0;
      id_valid <= 1'b0;
      if (branch_count != 16'hFFFF) begin
        branch_count <= branch_count + 16'd1;
      end
    end else if (freeze) begin
      if (stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end else begin
      pc       <= pc + 32'd4;
      id_instr <= instr_data;
      id_pc    <= pc;
      id_valid <= 1'b1;
    end
  end

endmodule
